ckpt_ctrl: RTL and testbench

- Checkpoint-slot manager for the rename stage's checkpointed RAT.
- Hands out up to two checkpoint IDs per cycle to branches being renamed, releases them in program order as branches commit, and trims younger slots on a misprediction.
- Sequences the RAT restore and holds off renaming for one cycle while it completes.
- Sits between rename, the RAT checkpoint storage and the ROB commit/flush ports.

---
 rtl/ckpt_ctrl_pkg.sv | 16 +
 rtl/ckpt_ctrl.sv | 91 +++++++++
 tb/tb_ckpt_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ckpt_ctrl_pkg.sv
// Shared types for the rename-stage RAT checkpoint manager.
// Default checkpoint count, ID/pointer typedefs and the restore FSM states.
package ckpt_ctrl_pkg;

  localparam int CKPT_NUM  = 4;
  localparam int CKPT_ID_W = $clog2(CKPT_NUM);

  typedef logic [CKPT_ID_W-1:0] ckpt_id_t;
  typedef logic [CKPT_ID_W:0]   ckpt_ptr_t;

  typedef enum logic {
    RUN     = 1'b0,
    RESTORE = 1'b1
  } ckpt_state_e;

endpackage

// File: rtl/ckpt_ctrl.sv
// Checkpoint slot allocator: up to two IDs per rename group, in-order release, flush trim + RAT restore.
// Latency: IDs/can_alloc_o combinational; restore pulse and busy_o one cycle after an accepted flush.
// Backpressure: can_alloc_o drops when free slots are short, on flush_i, and for the single RESTORE cycle.
module ckpt_ctrl
  import ckpt_ctrl_pkg::*;
#(
  parameter  int C_NUM = CKPT_NUM,
  localparam int ID_W  = $clog2(C_NUM)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_1_i,
  input  logic            br_2_i,
  input  logic            fire_i,
  output logic            can_alloc_o,
  output logic [ID_W-1:0] id_1_o,
  output logic [ID_W-1:0] id_2_o,
  input  logic            commit_br_i,
  input  logic            flush_i,
  input  logic [ID_W-1:0] flush_id_i,
  output logic            restore_o,
  output logic [ID_W-1:0] restore_id_o,
  output logic            busy_o,
  output logic [ID_W:0]   free_cnt_o,
  output logic            err_o
);

  localparam logic [ID_W:0] CAP = (ID_W+1)'(C_NUM);

  ckpt_state_e     state_q, state_d;
  logic [ID_W:0]   head_q, head_d, tail_q, tail_d;
  logic [ID_W:0]   used, need_w, flush_dist;
  logic [ID_W-1:0] flush_off, restore_id_d;
  logic            err_q, err_d;
  logic            live, alloc_go, commit_ok, flush_ok;

  always_comb begin
    used        = tail_q - head_q;
    free_cnt_o  = CAP - used;
    need_w      = (ID_W+1)'(br_1_i) + (ID_W+1)'(br_2_i);
    can_alloc_o = (need_w <= free_cnt_o) && (state_q == RUN) && !flush_i;
    id_1_o      = tail_q[ID_W-1:0];
    id_2_o      = tail_q[ID_W-1:0] + ID_W'(br_1_i);
    // Distance of the flushed slot from the (pre-commit) head decides liveness.
    flush_off   = flush_id_i - head_q[ID_W-1:0];
    flush_dist  = (ID_W+1)'(flush_off);
    live        = flush_dist < used;
  end

  always_comb begin
    alloc_go     = fire_i && can_alloc_o;
    commit_ok    = commit_br_i && (used != '0);
    flush_ok     = flush_i && (state_q == RUN) && live;
    state_d      = RUN;
    head_d       = head_q + (ID_W+1)'(commit_ok);
    tail_d       = tail_q;
    restore_id_d = restore_id_o;
    err_d        = err_q;
    if (flush_ok) begin
      state_d      = RESTORE;
      tail_d       = head_q + flush_dist + (ID_W+1)'(1);
      restore_id_d = flush_id_i;
    end else if (alloc_go) begin
      tail_d = tail_q + need_w;
    end
    if ((fire_i && !can_alloc_o) || (commit_br_i && (used == '0)) ||
        (flush_i && ((state_q == RESTORE) || !live)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      head_q       <= '0;
      tail_q       <= '0;
      restore_id_o <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      restore_id_o <= restore_id_d;
      err_q        <= err_d;
    end
  end

  assign restore_o = (state_q == RESTORE);
  assign busy_o    = (state_q == RESTORE);
  assign err_o     = err_q;

endmodule

// File: tb/tb_ckpt_ctrl.sv
// Bench for ckpt_ctrl: directed vector table, hand-written corner sequences and
// a randomized run against a counter-based model of allocations and releases.
module tb_ckpt_ctrl;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n, br_1_i, br_2_i, fire_i, commit_br_i, flush_i;
  logic [1:0] flush_id_i, id_1_o, id_2_o, restore_id_o;
  logic       can_alloc_o, restore_o, busy_o, err_o;
  logic [2:0] free_cnt_o;

  ckpt_ctrl dut (
    .clk(clk), .rst_n(rst_n), .br_1_i(br_1_i), .br_2_i(br_2_i), .fire_i(fire_i),
    .can_alloc_o(can_alloc_o), .id_1_o(id_1_o), .id_2_o(id_2_o),
    .commit_br_i(commit_br_i), .flush_i(flush_i), .flush_id_i(flush_id_i),
    .restore_o(restore_o), .restore_id_o(restore_id_o), .busy_o(busy_o),
    .free_cnt_o(free_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Model: total slots ever allocated / released; IDs are those totals mod C.
  int m_alloc = 0, m_rel = 0, m_rid = 0;
  bit m_restore = 0, m_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic bit m_can(input bit b1, input bit b2, input bit fl);
    int need = int'(b1) + int'(b2);
    return (need <= C - (m_alloc - m_rel)) && !m_restore && !fl;
  endfunction

  task automatic step(input bit rst, input bit b1, input bit b2, input bit fire,
                      input bit cmt, input bit fl, input int fid, input bit chk_en);
    int used, k_live;
    bit can;
    @(negedge clk);
    rst_n = !rst; br_1_i = b1; br_2_i = b2; fire_i = fire;
    commit_br_i = cmt; flush_i = fl; flush_id_i = 2'(fid);
    #1;
    used = m_alloc - m_rel;
    can  = m_can(b1, b2, fl);
    if (chk_en) begin
      chk("can_alloc", int'(can_alloc_o), int'(can));
      chk("id_1", int'(id_1_o), m_alloc % C);
      chk("id_2", int'(id_2_o), (m_alloc + int'(b1)) % C);
      chk("free_cnt", int'(free_cnt_o), C - used);
      chk("restore", int'(restore_o), int'(m_restore));
      chk("busy", int'(busy_o), int'(m_restore));
      chk("err", int'(err_o), int'(m_err));
      if (m_restore) chk("restore_id", int'(restore_id_o), m_rid);
    end
    k_live = -1;
    for (int k = 0; k < used; k++)
      if ((m_rel + k) % C == fid) k_live = k;
    if (rst) begin
      m_alloc = 0; m_rel = 0; m_restore = 0; m_err = 0; m_rid = 0;
    end else begin
      if ((fire && !can) || (cmt && used == 0) || (fl && (m_restore || k_live < 0)))
        m_err = 1;
      if (fl && !m_restore && k_live >= 0) begin
        m_rid = fid;
        m_restore = 1;
        m_alloc = m_rel + k_live + 1;
      end else begin
        m_restore = 0;
        if (fire && can) m_alloc += int'(b1) + int'(b2);
      end
      if (cmt && used > 0) m_rel++;
    end
  endtask

  typedef struct {
    bit b1, b2, fire, cmt, fl;
    int fid;
    int can, id1, id2, free, rst, rid, busy, err;
  } vec_t;

  function automatic vec_t mk(bit b1, bit b2, bit fire, bit cmt, bit fl, int fid,
                              int can, int id1, int id2, int free, int rst, int rid,
                              int busy, int err);
    vec_t v;
    v.b1 = b1; v.b2 = b2; v.fire = fire; v.cmt = cmt; v.fl = fl; v.fid = fid;
    v.can = can; v.id1 = id1; v.id2 = id2; v.free = free; v.rst = rst; v.rid = rid;
    v.busy = busy; v.err = err;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    bit b1, b2, fl, fire, cmt;
    // b1 b2 fire cmt fl fid | can id1 id2 free restore rid busy err
    tbl[0]  = mk(1,1,1,0,0,0, 1,0,1,4, 0,0,0,0);  // two IDs from empty
    tbl[1]  = mk(0,0,0,0,0,0, 1,2,2,2, 0,0,0,0);
    tbl[2]  = mk(1,1,1,0,0,0, 1,2,3,2, 0,0,0,0);  // fill to full
    tbl[3]  = mk(1,0,0,0,0,0, 0,0,1,0, 0,0,0,0);  // full: no alloc
    tbl[4]  = mk(1,0,0,1,0,0, 0,0,1,0, 0,0,0,0);  // release does not bypass
    tbl[5]  = mk(1,0,0,0,0,0, 1,0,1,1, 0,0,0,0);  // wrapped ID 0
    tbl[6]  = mk(1,0,1,0,0,0, 1,0,1,1, 0,0,0,0);
    tbl[7]  = mk(0,0,0,0,1,2, 0,1,1,0, 0,0,0,0);  // flush live ID 2
    tbl[8]  = mk(1,0,0,0,0,0, 0,3,0,2, 1,2,1,0);  // restore cycle
    tbl[9]  = mk(1,0,1,0,0,0, 1,3,0,2, 0,0,0,0);
    tbl[10] = mk(0,0,0,0,1,0, 0,0,0,1, 0,0,0,0);  // flush dead ID 0
    tbl[11] = mk(0,0,0,0,0,0, 1,0,0,1, 0,0,0,1);
    tbl[12] = mk(1,0,1,1,1,1, 0,0,1,1, 0,0,0,1);  // flush head + commit + fire
    tbl[13] = mk(0,1,0,0,0,0, 0,2,2,4, 1,1,1,1);
    tbl[14] = mk(0,1,1,0,0,0, 1,2,2,4, 0,0,0,1);  // slot-2-only branch gets tail
    tbl[15] = mk(0,0,0,0,0,0, 1,3,3,3, 0,0,0,1);

    rst_n = 0; br_1_i = 0; br_2_i = 0; fire_i = 0; commit_br_i = 0; flush_i = 0;
    flush_id_i = 0;
    step(1, 0,0,0,0,0,0, 0);
    step(1, 0,0,0,0,0,0, 0);

    for (int i = 0; i < 16; i++) begin
      step(0, tbl[i].b1, tbl[i].b2, tbl[i].fire, tbl[i].cmt, tbl[i].fl, tbl[i].fid, 1);
      chk($sformatf("vec%0d.can", i), int'(can_alloc_o), tbl[i].can);
      chk($sformatf("vec%0d.id1", i), int'(id_1_o), tbl[i].id1);
      chk($sformatf("vec%0d.id2", i), int'(id_2_o), tbl[i].id2);
      chk($sformatf("vec%0d.free", i), int'(free_cnt_o), tbl[i].free);
      chk($sformatf("vec%0d.restore", i), int'(restore_o), tbl[i].rst);
      chk($sformatf("vec%0d.busy", i), int'(busy_o), tbl[i].busy);
      chk($sformatf("vec%0d.err", i), int'(err_o), tbl[i].err);
      if (tbl[i].rst != 0) chk($sformatf("vec%0d.rid", i), int'(restore_id_o), tbl[i].rid);
    end

    // Reset clears sticky error; commit on empty sets it.
    step(1, 0,0,0,0,0,0, 1);
    step(0, 0,0,0,0,0,0, 1);
    chk("rst_free", int'(free_cnt_o), 4);
    chk("rst_err", int'(err_o), 0);
    step(0, 0,0,0,1,0,0, 1);
    step(0, 0,0,0,0,0,0, 1);
    chk("err_commit_empty", int'(err_o), 1);

    // Reset asserted during the restore cycle wins.
    step(1, 0,0,0,0,0,0, 1);
    step(0, 1,0,1,0,0,0, 1);
    step(0, 0,0,0,0,1,0, 1);
    step(1, 0,0,0,0,0,0, 1);
    chk("pulse_before_rst", int'(restore_o), 1);
    step(0, 0,0,0,0,0,0, 1);
    chk("rst_in_restore_busy", int'(busy_o), 0);
    chk("rst_in_restore_free", int'(free_cnt_o), 4);
    chk("rst_in_restore_err", int'(err_o), 0);

    for (int n = 0; n < 3000; n++) begin
      b1   = ($urandom % 2) == 1;
      b2   = ($urandom % 2) == 1;
      fl   = ($urandom % 8) == 0;
      cmt  = ($urandom % 3) == 0;
      fire = m_can(b1, b2, fl) ? (($urandom % 4) != 0) : (($urandom % 32) == 0);
      step(($urandom % 64) == 0, b1, b2, fire, cmt, fl, int'($urandom % C), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
